uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview: Synthesizable UART receiver that consumes the serial stream driven by the UART verification agent's transmitter. It recovers frames on the txd→rxd line using the same framing controls as the agent: 5–8 data bits, optional even/odd parity, 1 or 2 stop bits, and a 16-bit divisor. Received characters are presented through a single-entry valid/ready holding register to the UART register/FIFO stage, with parity, framing and overrun status.

Parameters:
SYNC_STAGES, 2, number of rxd synchronizer flops (min 2).
DIV_W, 16, width of cfg_div.

Ports:
mclk  input  1  system clock; all logic on posedge.
reset_n  input  1  reset, synchronous, active-low.
cfg_en  input  1  receiver enable; 0 forces IDLE and discards any partial frame.
cfg_data_bits  input  2  data bits = value+5 (0→5 … 3→8).
cfg_stop2  input  1  1 = two stop bits checked.
cfg_par_en  input  1  parity bit present.
cfg_par_even  input  1  1 = parity bit equals XOR of data; 0 = parity bit equals XNOR of data.
cfg_div  input  DIV_W  half-bit = cfg_div+1 mclk cycles; bit period T = 2*(cfg_div+1).
rxd  input  1  serial input, idle high, asynchronous.
rx_data  output  8  received character, LSB-aligned, unused upper bits 0.
rx_valid  output  1  holding register full.
rx_ready  input  1  consumer accepts on rx_valid&&rx_ready.
rx_perr  output  1  parity error for the held character.
rx_ferr  output  1  framing error (any stop bit sampled 0) for the held character.
rx_overrun  output  1  one-cycle pulse: frame completed while holding register full and not drained.
rx_busy  output  1  state != IDLE.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, rx_perr=0, rx_ferr=0, rx_overrun=0, rx_busy=0. Synchronizer flops reset to 1, state=IDLE, counters=0.
- rxd passes through SYNC_STAGES flops. All references to rxd below mean the synchronized value rxs.
- Config is latched at start detection. Changes to cfg_* mid-frame do not affect the current frame, except cfg_en=0, which aborts on the next cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: a 1→0 transition of rxs loads bit counter = cfg_div (counts down to 0, i.e. half-bit) → START.
- START: at counter 0, sample rxs. If 0 → DATA with counter = 2*cfg_div+1 (full bit). If 1 → false start, return to IDLE with no output.
- DATA: at each counter 0, shift rxs into bit[idx] (LSB first) and update parity accumulator. After data_bits samples, go to PARITY if par_en, else STOP1. Counter reloads the full bit each sample.
- PARITY: sample; perr = (sample != expected), where expected = even ? ^data : ~^data.
- STOP1: sample; ferr |= (sample==0). If cfg_stop2 → STOP2, else complete. STOP2: sample; ferr |= (sample==0); complete.
- Complete: FSM returns to IDLE in the same cycle as the final stop sample, so back-to-back start edges are caught. Frame is offered to the holding register in that cycle and is visible on rx_valid one cycle later.
- Holding register:
  - If empty, or rx_ready=1 in the completion cycle, load data/perr/ferr and set rx_valid=1.
  - Else drop the new frame, keep old contents, pulse rx_overrun for 1 cycle.
- rx_valid clears on rx_valid&&rx_ready with no simultaneous load.
- Latency: falling edge at rxd pin → rx_valid high ≈ SYNC_STAGES + (cfg_div+1) + T*(bits+par+stops−... per frame) + 1 cycles. Precisely: rx_valid rises 1 cycle after the last stop-bit mid sample.
- cfg_div=0 is legal (T=2). The bench uses values ≥1.
- reset_n low mid-frame: everything returns to reset values on the next edge.

Test Plan:
- 8N1, cfg_div=3 (T=8), agent sends 0xA5 → rx_valid with rx_data=0xA5, perr=0, ferr=0, rx_valid 1 cycle after stop mid-sample.
- 7E2 with cfg_par_even=1, agent sends 0x55 then 0x2A back-to-back, rx_ready=1 → two valids with 0x55 and 0x2A, no errors. 5O1 sends 0x1F → rx_data=0x1F.
- Agent stop_err_check=1, 8N1, sends 0x3C → rx_data=0x3C, rx_ferr=1. Parity flip (receiver par_even=0, agent even) sends 0x01 → rx_perr=1.
- rx_ready held 0, three frames 0x11, 0x22, 0x33 → rx_data stays 0x11, two rx_overrun pulses. Then rx_ready=1 for 1 cycle → rx_valid=0.
- 3-cycle low glitch on rxd with cfg_div=7 → no rx_valid, FSM back to IDLE after half-bit.
- reset_n=0 during DATA of 0xFF, then release, agent sends 0x81 → only 0x81 delivered. cfg_en=0 mid-frame → frame discarded, rx_busy=0 next cycle.

Source files
------------

// File: rtl/uart_rx_core_if.sv
// Receive-side character handoff between the UART receiver and the register/FIFO stage.
// Latency: none, wires only.
// Backpressure: the consumer holds rx_ready low to keep the character, and new frames then overrun.
interface uart_rx_core_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_perr;
    logic       rx_ferr;
    logic       rx_overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output rx_perr,
        output rx_ferr,
        output rx_overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  rx_perr,
        input  rx_ferr,
        input  rx_overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: 5-8 data bits, optional even/odd parity, 1/2 stop bits, programmable divisor.
// Latency: rx_valid rises 1 mclk after the mid-bit sample of the last stop bit.
// Backpressure: single-entry holding register; a frame completing while it is full and not drained is dropped and rx_overrun pulses.
module uart_rx_core #(
    parameter int SYNC_STAGES = 2,
    parameter int DIV_W       = 16
) (
    input  logic             mclk,
    input  logic             reset_n,
    input  logic             cfg_en,
    input  logic [1:0]       cfg_data_bits,
    input  logic             cfg_stop2,
    input  logic             cfg_par_en,
    input  logic             cfg_par_even,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             rxd,
    uart_rx_core_if.master   rx,
    output logic             rx_busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;

    // Frame format captured at start detection so mid-frame cfg changes are ignored.
    typedef struct packed {
        logic [1:0]       data_bits;
        logic             stop2;
        logic             par_en;
        logic             par_even;
        logic [DIV_W-1:0] div;
    } cfg_t;

    localparam logic [DIV_W:0] CNT_ONE = {{DIV_W{1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   rxs_q;

    state_t         state_q;
    state_t         state_nxt;
    cfg_t           cfg_q;
    logic [DIV_W:0] cnt_q;
    logic [2:0]     bit_idx_q;
    logic [7:0]     shift_q;
    logic           par_acc_q;
    logic           perr_q;
    logic           ferr_q;

    logic tick;
    logic start_det;
    logic last_bit;
    logic load_half;
    logic load_full;
    logic shift_en;
    logic par_smp;
    logic stop_smp;
    logic frame_done;
    logic frame_ferr;

    assign rxs       = sync_q[SYNC_STAGES-1];
    assign tick      = (cnt_q == '0);
    assign start_det = rxs_q & ~rxs;
    assign last_bit  = (bit_idx_q == ({1'b0, cfg_q.data_bits} + 3'd4));
    // Final stop sample is folded in combinationally so the completing frame carries it.
    assign frame_ferr = ferr_q | (stop_smp & ~rxs);

    // Bring rxd into the mclk domain and keep one delayed copy for falling-edge detection.
    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            sync_q <= '1;
            rxs_q  <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
            rxs_q  <= rxs;
        end
    end

    // Frame state register.
    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state: advance on each mid-bit sample; disabling the receiver aborts immediately.
    always_comb begin
        state_nxt = state_q;
        if (!cfg_en) begin
            state_nxt = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_det) state_nxt = START;
                START:   if (tick) state_nxt = rxs ? IDLE : DATA;
                DATA:    if (tick && last_bit) state_nxt = cfg_q.par_en ? PARITY : STOP1;
                PARITY:  if (tick) state_nxt = STOP1;
                STOP1:   if (tick) state_nxt = cfg_q.stop2 ? STOP2 : IDLE;
                STOP2:   if (tick) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Per-state strobes driving the counter, shifter, error flags and holding register.
    always_comb begin
        load_half  = 1'b0;
        load_full  = 1'b0;
        shift_en   = 1'b0;
        par_smp    = 1'b0;
        stop_smp   = 1'b0;
        frame_done = 1'b0;
        rx_busy    = (state_q != IDLE);
        if (cfg_en) begin
            case (state_q)
                IDLE:   load_half = start_det;
                START:  load_full = tick & ~rxs;
                DATA: begin
                    shift_en  = tick;
                    load_full = tick;
                end
                PARITY: begin
                    par_smp   = tick;
                    load_full = tick;
                end
                STOP1: begin
                    stop_smp   = tick;
                    load_full  = tick & cfg_q.stop2;
                    frame_done = tick & ~cfg_q.stop2;
                end
                STOP2: begin
                    stop_smp   = tick;
                    frame_done = tick;
                end
                default: begin
                    load_half = 1'b0;
                end
            endcase
        end
    end

    // Bit timer, data shifter and parity/framing accumulators for the frame in flight.
    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            cfg_q     <= '0;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_acc_q <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else if (load_half) begin
            cfg_q.data_bits <= cfg_data_bits;
            cfg_q.stop2     <= cfg_stop2;
            cfg_q.par_en    <= cfg_par_en;
            cfg_q.par_even  <= cfg_par_even;
            cfg_q.div       <= cfg_div;
            cnt_q           <= {1'b0, cfg_div};
            bit_idx_q       <= '0;
            shift_q         <= '0;
            par_acc_q       <= 1'b0;
            perr_q          <= 1'b0;
            ferr_q          <= 1'b0;
        end else begin
            if (!cfg_en) begin
                cnt_q <= '0;
            end else if (load_full) begin
                cnt_q <= {cfg_q.div, 1'b1};
            end else if (!tick) begin
                cnt_q <= cnt_q - CNT_ONE;
            end
            if (shift_en) begin
                shift_q[bit_idx_q] <= rxs;
                bit_idx_q          <= bit_idx_q + 3'd1;
                par_acc_q          <= par_acc_q ^ rxs;
            end
            if (par_smp) begin
                perr_q <= (rxs != (cfg_q.par_even ? par_acc_q : ~par_acc_q));
            end
            if (stop_smp) begin
                ferr_q <= frame_ferr;
            end
        end
    end

    // Single-entry holding register: accept when empty or being drained, otherwise flag overrun.
    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            rx.rx_data    <= '0;
            rx.rx_valid   <= 1'b0;
            rx.rx_perr    <= 1'b0;
            rx.rx_ferr    <= 1'b0;
            rx.rx_overrun <= 1'b0;
        end else begin
            rx.rx_overrun <= 1'b0;
            if (frame_done) begin
                if (!rx.rx_valid || rx.rx_ready) begin
                    rx.rx_data  <= shift_q;
                    rx.rx_perr  <= perr_q;
                    rx.rx_ferr  <= frame_ferr;
                    rx.rx_valid <= 1'b1;
                end else begin
                    rx.rx_overrun <= 1'b1;
                end
            end else if (rx.rx_valid && rx.rx_ready) begin
                rx.rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: table vectors, corner-case sequences, randomized frames.
// Latency: n/a.
// Backpressure: rx_ready driven by the bench.
module tb_uart_rx_core;

    logic        mclk;
    logic        reset_n;
    logic        cfg_en;
    logic [1:0]  cfg_data_bits;
    logic        cfg_stop2;
    logic        cfg_par_en;
    logic        cfg_par_even;
    logic [15:0] cfg_div;
    logic        rxd;
    logic        rx_busy;

    uart_rx_core_if u_if ();

    uart_rx_core #(.SYNC_STAGES(2), .DIV_W(16)) u_dut (
        .mclk          (mclk),
        .reset_n       (reset_n),
        .cfg_en        (cfg_en),
        .cfg_data_bits (cfg_data_bits),
        .cfg_stop2     (cfg_stop2),
        .cfg_par_en    (cfg_par_en),
        .cfg_par_even  (cfg_par_even),
        .cfg_div       (cfg_div),
        .rxd           (rxd),
        .rx            (u_if),
        .rx_busy       (rx_busy)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       f;
    } rec_t;

    typedef struct {
        logic [7:0] d;
        int         nb;
        bit         pe;
        bit         rx_even;
        bit         tx_even;
        int         ns;
        logic [1:0] sbad;
        int         div;
        logic [7:0] exp_d;
        bit         exp_p;
        bit         exp_f;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   rise_n  = 0;
    int   last_rise_cyc = 0;
    int   ovr_n   = 0;
    int   busy_n  = 0;
    logic valid_prev = 1'b0;
    rec_t got_q[$];
    rec_t exp_q[$];

    always @(posedge mclk) cyc++;

    // Observe handshakes, rx_valid rising edges, overrun pulses and busy cycles.
    always @(negedge mclk) begin
        if (reset_n) begin
            if (u_if.rx_valid && u_if.rx_ready)
                got_q.push_back('{d: u_if.rx_data, p: u_if.rx_perr, f: u_if.rx_ferr});
            if (u_if.rx_valid && !valid_prev) begin
                rise_n++;
                last_rise_cyc = cyc;
            end
            if (u_if.rx_overrun) ovr_n++;
            if (rx_busy) busy_n++;
        end
        valid_prev = u_if.rx_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic drive_bit(input logic b, input int t);
        rxd = b;
        tick(t);
    endtask

    task automatic configure(input int nb, input bit pe, input bit rx_even, input int ns, input int div);
        cfg_data_bits = 2'(nb - 5);
        cfg_par_en    = pe;
        cfg_par_even  = rx_even;
        cfg_stop2     = (ns == 2);
        cfg_div       = 16'(div);
    endtask

    // Transmit one frame as the agent would: start, LSB-first data, parity, stop bits.
    task automatic send_frame(input logic [7:0] d, input int nb, input bit pe, input bit tx_even,
                              input int ns, input logic [1:0] sbad, input int t);
        logic [7:0] m;
        logic       pbit;
        m    = 8'((1 << nb) - 1);
        pbit = ^(d & m);
        if (!tx_even) pbit = ~pbit;
        drive_bit(1'b0, t);
        for (int i = 0; i < nb; i++) drive_bit(d[i], t);
        if (pe) drive_bit(pbit, t);
        for (int j = 0; j < ns; j++) drive_bit(~sbad[j], t);
    endtask

    vec_t vecs[6];

    initial begin
        int   rn0;
        int   c0;
        int   base;
        int   ov0;
        int   bz0;
        int   t;

        vecs[0] = '{d: 8'hA5, nb: 8, pe: 0, rx_even: 0, tx_even: 0, ns: 1, sbad: 2'b00, div: 3, exp_d: 8'hA5, exp_p: 0, exp_f: 0};
        vecs[1] = '{d: 8'h1F, nb: 5, pe: 1, rx_even: 0, tx_even: 0, ns: 1, sbad: 2'b00, div: 3, exp_d: 8'h1F, exp_p: 0, exp_f: 0};
        vecs[2] = '{d: 8'h3C, nb: 8, pe: 0, rx_even: 0, tx_even: 0, ns: 1, sbad: 2'b01, div: 3, exp_d: 8'h3C, exp_p: 0, exp_f: 1};
        vecs[3] = '{d: 8'h01, nb: 8, pe: 1, rx_even: 0, tx_even: 1, ns: 1, sbad: 2'b00, div: 3, exp_d: 8'h01, exp_p: 1, exp_f: 0};
        vecs[4] = '{d: 8'hEB, nb: 6, pe: 1, rx_even: 1, tx_even: 1, ns: 1, sbad: 2'b00, div: 2, exp_d: 8'h2B, exp_p: 0, exp_f: 0};
        vecs[5] = '{d: 8'h40, nb: 7, pe: 1, rx_even: 0, tx_even: 0, ns: 2, sbad: 2'b10, div: 1, exp_d: 8'h40, exp_p: 0, exp_f: 1};

        reset_n         = 1'b0;
        cfg_en          = 1'b1;
        rxd             = 1'b1;
        u_if.rx_ready   = 1'b1;
        configure(8, 0, 0, 1, 3);
        tick(5);
        check("reset_outputs",
              32'({u_if.rx_data, u_if.rx_valid, u_if.rx_perr, u_if.rx_ferr, u_if.rx_overrun, rx_busy}), 32'd0);
        reset_n = 1'b1;
        tick(10);

        // Table-driven single frames with rx_ready held high.
        for (int i = 0; i < 6; i++) begin
            configure(vecs[i].nb, vecs[i].pe, vecs[i].rx_even, vecs[i].ns, vecs[i].div);
            t    = 2 * (vecs[i].div + 1);
            rn0  = rise_n;
            base = got_q.size();
            c0   = cyc;
            send_frame(vecs[i].d, vecs[i].nb, vecs[i].pe, vecs[i].tx_even, vecs[i].ns, vecs[i].sbad, t);
            drive_bit(1'b1, t);
            tick(4);
            check($sformatf("vec%0d_count", i), 32'(got_q.size() - base), 32'd1);
            if (got_q.size() > base) begin
                check($sformatf("vec%0d_data", i), 32'(got_q[base].d), 32'(vecs[i].exp_d));
                check($sformatf("vec%0d_perr", i), 32'(got_q[base].p), 32'(vecs[i].exp_p));
                check($sformatf("vec%0d_ferr", i), 32'(got_q[base].f), 32'(vecs[i].exp_f));
            end
            check($sformatf("vec%0d_latency", i), 32'(last_rise_cyc - c0),
                  32'(2 + 1 + (vecs[i].div + 1) + (vecs[i].nb + int'(vecs[i].pe) + vecs[i].ns) * t));
            check($sformatf("vec%0d_rises", i), 32'(rise_n - rn0), 32'd1);
        end

        // 7E2 back-to-back frames.
        configure(7, 1, 1, 2, 3);
        base = got_q.size();
        send_frame(8'h55, 7, 1, 1, 2, 2'b00, 8);
        send_frame(8'h2A, 7, 1, 1, 2, 2'b00, 8);
        drive_bit(1'b1, 8);
        tick(4);
        check("b2b_count", 32'(got_q.size() - base), 32'd2);
        if (got_q.size() >= base + 2) begin
            check("b2b_first", 32'(got_q[base]), 32'({8'h55, 1'b0, 1'b0}));
            check("b2b_second", 32'(got_q[base + 1]), 32'({8'h2A, 1'b0, 1'b0}));
        end

        // Overrun: consumer stalled for three frames.
        configure(8, 0, 0, 1, 3);
        u_if.rx_ready = 1'b0;
        ov0 = ovr_n;
        send_frame(8'h11, 8, 0, 0, 1, 2'b00, 8);
        send_frame(8'h22, 8, 0, 0, 1, 2'b00, 8);
        send_frame(8'h33, 8, 0, 0, 1, 2'b00, 8);
        drive_bit(1'b1, 8);
        check("ovr_pulses", 32'(ovr_n - ov0), 32'd2);
        check("ovr_held_data", 32'(u_if.rx_data), 32'h11);
        check("ovr_valid_held", 32'(u_if.rx_valid), 32'd1);
        base = got_q.size();
        u_if.rx_ready = 1'b1;
        tick(1);
        u_if.rx_ready = 1'b0;
        check("ovr_drain_valid", 32'(u_if.rx_valid), 32'd0);
        check("ovr_drain_data", 32'(got_q.size() > base ? got_q[base].d : 8'h00), 32'h11);
        u_if.rx_ready = 1'b1;
        tick(4);

        // Short low glitch: false start, back to idle after half a bit.
        configure(8, 0, 0, 1, 7);
        rn0 = rise_n;
        bz0 = busy_n;
        drive_bit(1'b0, 3);
        drive_bit(1'b1, 40);
        check("glitch_busy_cycles", 32'(busy_n - bz0), 32'd8);
        check("glitch_no_valid", 32'(rise_n - rn0), 32'd0);
        check("glitch_idle", 32'(rx_busy), 32'd0);

        // Reset in the middle of a 0xFF frame, then a clean 0x81.
        configure(8, 0, 0, 1, 3);
        rn0  = rise_n;
        base = got_q.size();
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 8);
        check("rst_busy_before", 32'(rx_busy), 32'd1);
        reset_n = 1'b0;
        tick(1);
        check("rst_busy_after", 32'(rx_busy), 32'd0);
        check("rst_valid_after", 32'(u_if.rx_valid), 32'd0);
        reset_n = 1'b1;
        drive_bit(1'b1, 80);
        send_frame(8'h81, 8, 0, 0, 1, 2'b00, 8);
        drive_bit(1'b1, 8);
        check("rst_frames", 32'(got_q.size() - base), 32'd1);
        check("rst_data", 32'(got_q.size() > base ? got_q[got_q.size() - 1].d : 8'h00), 32'h81);

        // Receiver disabled mid-frame.
        rn0 = rise_n;
        drive_bit(1'b0, 8);
        drive_bit(1'b0, 8);
        check("en_busy_before", 32'(rx_busy), 32'd1);
        cfg_en = 1'b0;
        tick(1);
        check("en_busy_after", 32'(rx_busy), 32'd0);
        drive_bit(1'b1, 16);
        cfg_en = 1'b1;
        tick(80);
        check("en_discarded", 32'(rise_n - rn0), 32'd0);

        // Randomized frames against a frame-level reference model.
        base = got_q.size();
        exp_q.delete();
        for (int f = 0; f < 40; f++) begin
            int         nb;
            int         ns;
            int         dv;
            bit         pe;
            bit         rxe;
            bit         txe;
            logic [7:0] d;
            logic [7:0] dm;
            logic [1:0] sb;
            logic       psent;
            logic       pwant;
            nb  = $urandom_range(5, 8);
            ns  = $urandom_range(1, 2);
            dv  = $urandom_range(1, 4);
            pe  = 1'($urandom_range(0, 1));
            rxe = 1'($urandom_range(0, 1));
            txe = 1'($urandom_range(0, 1));
            d   = 8'($urandom);
            sb  = 2'b00;
            if ($urandom_range(0, 7) == 0) sb[0] = 1'b1;
            if ($urandom_range(0, 7) == 0) sb[1] = 1'b1;
            dm    = d & 8'((1 << nb) - 1);
            psent = txe ? ($countones(dm) % 2 == 1) : ($countones(dm) % 2 == 0);
            pwant = rxe ? ($countones(dm) % 2 == 1) : ($countones(dm) % 2 == 0);
            exp_q.push_back('{d: dm, p: pe && (psent != pwant), f: (ns == 2) ? (sb != 2'b00) : sb[0]});
            configure(nb, pe, rxe, ns, dv);
            t = 2 * (dv + 1);
            send_frame(d, nb, pe, txe, ns, sb, t);
            drive_bit(1'b1, t + int'($urandom_range(0, 5)));
        end
        tick(20);
        check("rand_count", 32'(got_q.size() - base), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            if (base + k < got_q.size())
                check($sformatf("rand_frame%0d", k), 32'(got_q[base + k]), 32'(exp_q[k]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
